// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types, default widths and helpers for the SDRAM request-port arbiter.
package sdram_arb_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    // Plain vector encodings of the state enum, for code that keeps state as logic.
    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE     = 2'(ISSUE);
    localparam logic [1:0] ST_WAIT_RESP = 2'(WAIT_RESP);

    function automatic int wmask_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int owner_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side bundles of the SDRAM request-port arbiter.
interface sdram_req_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int WMASK_W = wmask_width(DATA_W);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata;
    logic [NUM_REQ*WMASK_W-1:0] req_wmask;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [DATA_W-1:0]          resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

interface sdram_mem_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int WMASK_W = wmask_width(DATA_W);

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_write;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [WMASK_W-1:0] mem_wmask;
    logic               mem_resp_valid;
    logic [DATA_W-1:0]  mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_write, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/sdram_port_arbiter_rr_picker.sv
// Rotating-priority encoder: first set request bit at or after i_ptr, wrapping.
module rr_picker
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int OWN_W   = owner_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [OWN_W-1:0]   i_ptr,
    output logic [OWN_W-1:0]   o_grant,
    output logic               o_any
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_grant = '0;
        o_any   = |i_req;
        // Walk from farthest to nearest so the candidate closest to i_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[idx]) begin
                o_grant = OWN_W'(idx);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_REQ requesters,
// one transaction in flight, responses routed back to the granted requester.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OWN_W   = owner_width(NUM_REQ)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    sdram_req_if.slave       req,
    sdram_mem_if.master      mem,
    output logic             o_busy,
    output logic [OWN_W-1:0] o_owner_id
);

    localparam int WMASK_W = wmask_width(DATA_W);

    logic [1:0]         r_state;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   r_rr_ptr;

    logic [OWN_W-1:0]   w_grant;
    logic               w_any;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic [OWN_W-1:0]   w_next_ptr;
    int                 w_owner_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_picker (
        .i_req   (req.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    assign w_owner_idx    = int'(r_owner);
    assign w_owner_onehot = NUM_REQ'(1) << r_owner;
    assign w_next_ptr     = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_grant;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem.mem_req_ready) begin
                        r_state <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (mem.mem_resp_valid) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Payload is not latched: the requester holds it stable until its req_ready.
    always_comb begin
        mem.mem_req_valid = (r_state == ST_ISSUE);
        mem.mem_write     = req.req_write[r_owner];
        mem.mem_addr      = req.req_addr[w_owner_idx*ADDR_W +: ADDR_W];
        mem.mem_wdata     = req.req_wdata[w_owner_idx*DATA_W +: DATA_W];
        mem.mem_wmask     = req.req_wmask[w_owner_idx*WMASK_W +: WMASK_W];
    end

    always_comb begin
        req.req_ready  = '0;
        req.resp_valid = '0;
        req.resp_rdata = mem.mem_resp_rdata;
        if (r_state == ST_ISSUE && mem.mem_req_ready) begin
            req.req_ready = w_owner_onehot;
        end
        if (r_state == ST_WAIT_RESP && mem.mem_resp_valid) begin
            req.resp_valid = w_owner_onehot;
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_owner_id = r_owner;

    a_payload_stable: assert property (
        @(posedge i_clock) disable iff (i_reset)
        (r_state == ST_ISSUE && !mem.mem_req_ready) |=>
            $stable({mem.mem_write, mem.mem_addr, mem.mem_wdata, mem.mem_wmask})
    );

    // Flagged without stopping the system: a stray completion is simply dropped.
    a_no_stray_resp: assert property (
        @(posedge i_clock) disable iff (i_reset)
        mem.mem_resp_valid |-> (r_state == ST_WAIT_RESP)
    ) else $warning("mem_resp_valid outside WAIT_RESP ignored");

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter with two requesters.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 32;
    localparam int WMASK_W = DATA_W / 8;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [0:0] owner_id;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_req_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();
    sdram_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    sdram_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .req        (req_if),
        .mem        (mem_if),
        .o_busy     (busy),
        .o_owner_id (owner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [WMASK_W-1:0] wmask);
        req_if.req_write[p]                    = wr;
        req_if.req_addr[p*ADDR_W +: ADDR_W]    = addr;
        req_if.req_wdata[p*DATA_W +: DATA_W]   = wdata;
        req_if.req_wmask[p*WMASK_W +: WMASK_W] = wmask;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [0:0] prev_owner;

        rst                   = 1'b1;
        req_if.req_valid      = '0;
        req_if.req_write      = '0;
        req_if.req_addr       = '0;
        req_if.req_wdata      = '0;
        req_if.req_wmask      = '0;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_rdata = '0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("rst_req_ready", 64'(req_if.req_ready), 64'd0);
        check("rst_resp_valid", 64'(req_if.resp_valid), 64'd0);
        check("rst_owner", 64'(owner_id), 64'd0);
        rst = 1'b0;

        // Single read from port 0
        set_port(0, 1'b0, 25'h0000123, 32'h0, 4'h0);
        set_port(1, 1'b1, 25'h1FFFFFF, 32'hFFFF_FFFF, 4'hF);
        req_if.req_valid     = 2'b01;
        mem_if.mem_req_ready = 1'b1;
        #1;
        check("rd_idle_no_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("rd_idle_no_ready", 64'(req_if.req_ready), 64'd0);
        tick();
        #1;
        check("rd_mem_valid", 64'(mem_if.mem_req_valid), 64'd1);
        check("rd_mem_addr", 64'(mem_if.mem_addr), 64'h123);
        check("rd_mem_write", 64'(mem_if.mem_write), 64'd0);
        check("rd_req_ready", 64'(req_if.req_ready), 64'b01);
        check("rd_owner", 64'(owner_id), 64'd0);
        tick();
        req_if.req_valid      = 2'b00;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_mem_valid_dropped", 64'(mem_if.mem_req_valid), 64'd0);
        check("rd_resp_valid", 64'(req_if.resp_valid), 64'b01);
        check("rd_resp_rdata", 64'(req_if.resp_rdata), 64'hDEAD_BEEF);
        check("rd_busy_wait", 64'(busy), 64'd1);
        tick();
        mem_if.mem_resp_valid = 1'b0;
        #1;
        check("rd_back_idle", 64'(busy), 64'd0);
        check("rd_resp_cleared", 64'(req_if.resp_valid), 64'd0);

        // Both ports continuously valid: strict alternation starting at port 0
        do_reset();
        set_port(0, 1'b0, 25'h0000100, 32'h0, 4'h0);
        set_port(1, 1'b0, 25'h0000200, 32'h0, 4'h0);
        req_if.req_valid     = 2'b11;
        mem_if.mem_req_ready = 1'b1;
        prev_owner           = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            check("rr_idle_bubble", 64'(mem_if.mem_req_valid), 64'd0);
            tick();
            #1;
            check("rr_owner", 64'(owner_id), 64'(t % 2));
            check("rr_alternates", 64'(owner_id != prev_owner), 64'd1);
            check("rr_req_ready", 64'(req_if.req_ready), 64'(1 << (t % 2)));
            check("rr_mem_addr", 64'(mem_if.mem_addr), (t % 2 == 0) ? 64'h100 : 64'h200);
            prev_owner = owner_id;
            tick();
            mem_if.mem_resp_valid = 1'b1;
            mem_if.mem_resp_rdata = 32'(t);
            #1;
            check("rr_resp_valid", 64'(req_if.resp_valid), 64'(1 << (t % 2)));
            tick();
            mem_if.mem_resp_valid = 1'b0;
        end
        req_if.req_valid = 2'b00;

        // Port 1 write stalled by mem_req_ready for 3 cycles
        do_reset();
        set_port(0, 1'b0, 25'h0000555, 32'h1111_1111, 4'b1100);
        set_port(1, 1'b1, 25'h1ABCDEF, 32'hA5A5_5A5A, 4'b0011);
        req_if.req_valid     = 2'b10;
        mem_if.mem_req_ready = 1'b0;
        pulses               = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_if.mem_req_ready = (i == 3);
            #1;
            check("wr_mem_valid", 64'(mem_if.mem_req_valid), 64'd1);
            check("wr_mem_write", 64'(mem_if.mem_write), 64'd1);
            check("wr_mem_addr", 64'(mem_if.mem_addr), 64'h1ABCDEF);
            check("wr_mem_wdata", 64'(mem_if.mem_wdata), 64'hA5A5_5A5A);
            check("wr_mem_wmask", 64'(mem_if.mem_wmask), 64'b0011);
            check("wr_req_ready", 64'(req_if.req_ready), (i == 3) ? 64'b10 : 64'b00);
            if (req_if.req_ready[1]) pulses++;
            tick();
        end
        check("wr_ready_pulses", 64'(pulses), 64'd1);
        req_if.req_valid      = 2'b00;
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b1;
        #1;
        check("wr_resp_valid", 64'(req_if.resp_valid), 64'b10);
        tick();
        mem_if.mem_resp_valid = 1'b0;

        // Only port 1 active: re-granted every time, one IDLE bubble between
        set_port(1, 1'b0, 25'h0000040, 32'h0, 4'h0);
        req_if.req_valid     = 2'b10;
        mem_if.mem_req_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            #1;
            check("solo_bubble_busy", 64'(busy), 64'd0);
            check("solo_bubble_valid", 64'(mem_if.mem_req_valid), 64'd0);
            tick();
            #1;
            check("solo_owner", 64'(owner_id), 64'd1);
            check("solo_mem_valid", 64'(mem_if.mem_req_valid), 64'd1);
            tick();
            mem_if.mem_resp_valid = 1'b1;
            mem_if.mem_resp_rdata = 32'hC0DE_0000 + 32'(t);
            #1;
            check("solo_resp_valid", 64'(req_if.resp_valid), 64'b10);
            check("solo_resp_rdata", 64'(req_if.resp_rdata), 64'hC0DE_0000 + 64'(t));
            tick();
            mem_if.mem_resp_valid = 1'b0;
        end
        req_if.req_valid     = 2'b00;
        mem_if.mem_req_ready = 1'b0;

        // Stray completion while idle is dropped
        mem_if.mem_resp_valid = 1'b1;
        mem_if.mem_resp_rdata = 32'h5555_AAAA;
        #1;
        check("stray_resp_valid", 64'(req_if.resp_valid), 64'd0);
        check("stray_busy", 64'(busy), 64'd0);
        tick();
        check("stray_still_idle", 64'(busy), 64'd0);
        check("stray_resp_after", 64'(req_if.resp_valid), 64'd0);
        mem_if.mem_resp_valid = 1'b0;

        // Reset asserted mid-WAIT_RESP with owner 1
        req_if.req_valid     = 2'b10;
        mem_if.mem_req_ready = 1'b1;
        tick();
        #1;
        check("midrst_owner_pre", 64'(owner_id), 64'd1);
        tick();
        req_if.req_valid     = 2'b00;
        mem_if.mem_req_ready = 1'b0;
        #1;
        check("midrst_busy_pre", 64'(busy), 64'd1);
        #1;
        rst                   = 1'b1;
        mem_if.mem_resp_valid = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_owner", 64'(owner_id), 64'd0);
        check("midrst_resp_valid", 64'(req_if.resp_valid), 64'd0);
        check("midrst_mem_valid", 64'(mem_if.mem_req_valid), 64'd0);
        check("midrst_req_ready", 64'(req_if.req_ready), 64'd0);
        tick();
        rst                   = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        tick();
        check("midrst_after_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
